// File: rtl/stream_mux_pkg.sv
// Shared constants for the stream multiplexer: mode encodings and the channel-count limit.
package stream_mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  localparam int unsigned MAX_CHANNELS = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after `i_last`,
// wrapping from CHANNELS-1 to 0.
module rr_arbiter #(
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] i_req,
  input  logic [SEL_W-1:0]    i_last,
  output logic                o_grant_valid,
  output logic [SEL_W-1:0]    o_grant
);

  int unsigned w_idx;

  always_comb begin
    o_grant_valid = 1'b0;
    o_grant       = '0;
    w_idx         = 0;
    for (int unsigned k = 1; k <= CHANNELS; k++) begin
      w_idx = (int'(i_last) + k) % CHANNELS;
      if (!o_grant_valid && i_req[w_idx]) begin
        o_grant_valid = 1'b1;
        o_grant       = SEL_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel registered stream mux: direct-select or round-robin grant feeding a
// single output register, with the granted channel index alongside the data.
module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter  int unsigned WIDTH    = 4,
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_chan;
  logic [SEL_W-1:0] r_last;

  logic             w_rr_gv;
  logic [SEL_W-1:0] w_rr_grant;
  logic             w_sel_gv;
  logic             w_gv;
  logic [SEL_W-1:0] w_grant;
  logic             w_load_en;
  logic             w_xfer;
  logic [WIDTH-1:0] w_mux_data;

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_rr_arbiter (
    .i_req         (in_valid),
    .i_last        (r_last),
    .o_grant_valid (w_rr_gv),
    .o_grant       (w_rr_grant)
  );

  // Compare against every legal index so an out-of-range sel simply never matches.
  always_comb begin
    w_sel_gv = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (sel == SEL_W'(i) && in_valid[i]) w_sel_gv = 1'b1;
    end
  end

  assign w_gv      = (mode == MODE_RR) ? w_rr_gv : w_sel_gv;
  assign w_grant   = (mode == MODE_RR) ? w_rr_grant : sel;
  assign w_load_en = !r_out_valid || out_ready;
  assign w_xfer    = w_gv && w_load_en && !rst;

  // Ready is also held low while reset is asserted, not only via out_valid.
  always_comb begin
    in_ready   = '0;
    w_mux_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (w_grant == SEL_W'(i)) begin
        in_ready[i] = w_xfer;
        w_mux_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_last      <= SEL_W'(CHANNELS - 1);
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux_data;
      r_out_chan  <= w_grant;
      if (mode == MODE_RR) r_last <= w_grant;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Self-checking bench for stream_mux_arb: scoreboard-driven 4-channel instance
// plus a 3-channel instance for out-of-range select and mode switching.
module tb_stream_mux_arb;

  typedef struct packed {
    logic [1:0] chan;
    logic [3:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [15:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_ready;

  logic        mode3;
  logic [1:0]  sel3;
  logic [2:0]  in_valid3;
  logic [11:0] in_data3;
  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [3:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_ready3;

  int n_chk;
  int n_pass;

  exp_t       sb[$];
  logic [1:0] seq[$];
  logic       m_valid;
  int         m_last;
  logic       refresh;

  stream_mux_arb #(
    .WIDTH    (4),
    .CHANNELS (4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  stream_mux_arb #(
    .WIDTH    (4),
    .CHANNELS (3)
  ) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode3),
    .sel       (sel3),
    .in_valid  (in_valid3),
    .in_data   (in_data3),
    .in_ready  (in_ready3),
    .out_valid (out_valid3),
    .out_data  (out_data3),
    .out_chan  (out_chan3),
    .out_ready (out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of the 4-channel scoreboard; called at a negedge with inputs set.
  task automatic run_cycle();
    logic       gv;
    logic       load;
    logic [3:0] exp_rdy;
    int         g;
    int         c;
    exp_t       e;
    #1;
    gv = 1'b0;
    g  = 0;
    if (mode == 1'b0) begin
      g  = int'(sel);
      gv = in_valid[g];
    end else begin
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (!gv && in_valid[c]) begin
          gv = 1'b1;
          g  = c;
        end
      end
    end
    load    = !m_valid || out_ready;
    exp_rdy = (load && gv) ? 4'(1 << g) : 4'b0;
    n_chk++;
    if (out_valid !== m_valid) $display("FAIL out_valid: got %b want %b", out_valid, m_valid);
    else n_pass++;
    n_chk++;
    if (in_ready !== exp_rdy) $display("FAIL in_ready: got %b want %b", in_ready, exp_rdy);
    else n_pass++;
    if (m_valid && out_ready) begin
      n_chk++;
      if (sb.size() == 0) begin
        $display("FAIL sb_underflow: got word chan %0d want none", out_chan);
      end else begin
        e = sb.pop_front();
        if (out_chan !== e.chan || out_data !== e.data)
          $display("FAIL out_word: got chan %0d data %h want chan %0d data %h",
                   out_chan, out_data, e.chan, e.data);
        else n_pass++;
      end
      seq.push_back(out_chan);
    end
    if (load && gv) begin
      e.chan = 2'(g);
      e.data = in_data[g*4 +: 4];
      sb.push_back(e);
      if (mode) m_last = g;
      m_valid = 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    if (load && gv && refresh) in_data[g*4 +: 4] = 4'($urandom);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; sel = 2'd0; in_valid = 4'hF; in_data = 16'h4321; out_ready = 1'b1;
    mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b0; in_data3 = 12'hCBA; out_ready3 = 1'b1;
    m_valid = 1'b0; m_last = 3; refresh = 1'b0;
    #2;
    n_chk++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || out_chan !== 2'd0)
      $display("FAIL reset_out: got v%b d%h c%0d want v0 d0 c0", out_valid, out_data, out_chan);
    else n_pass++;
    n_chk++;
    if (in_ready !== 4'b0) $display("FAIL reset_ready: got %b want 0000", in_ready);
    else n_pass++;
    in_valid = 4'h0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sel();
    mode = 1'b0; sel = 2'd2; in_valid = 4'hF; in_data = 16'h4321; out_ready = 1'b1;
    refresh = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      n_chk++;
      if (out_valid !== 1'b1 || out_chan !== 2'd2 || out_data !== 4'h3)
        $display("FAIL sel_word: got v%b c%0d d%h want v1 c2 d3", out_valid, out_chan, out_data);
      else n_pass++;
    end
  endtask

  task automatic test_sel_invalid();
    sel = 2'd1; in_valid = 4'b1101;
    run_cycle();
    run_cycle();
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0)
      $display("FAIL sel_invalid: got v%b rdy %b want v0 rdy 0000", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] want [6];
    want = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1; refresh = 1'b1;
    seq.delete();
    for (int i = 0; i < 8; i++) run_cycle();
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (seq.size() <= i || seq[i] !== want[i])
        $display("FAIL rr_order[%0d]: got %0d want %0d", i, (seq.size() > i) ? seq[i] : 2'd0, want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_rr_sparse_backpressure();
    logic [1:0] want [4];
    want = '{2'd1, 2'd3, 2'd1, 2'd3};
    in_valid = 4'b1010;
    seq.delete();
    for (int i = 0; i < 5; i++) run_cycle();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (seq.size() <= i + 1 || seq[i+1] !== want[i])
        $display("FAIL sparse_order[%0d]: got %0d want %0d", i,
                 (seq.size() > i + 1) ? seq[i+1] : 2'd0, want[i]);
      else n_pass++;
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      n_chk++;
      if (sb.size() == 0 || out_chan !== sb[0].chan || out_data !== sb[0].data)
        $display("FAIL hold_word: got c%0d d%h want c%0d d%h", out_chan, out_data,
                 (sb.size() > 0) ? sb[0].chan : 2'd0, (sb.size() > 0) ? sb[0].data : 4'd0);
      else n_pass++;
    end
    out_ready = 1'b1;
    seq.delete();
    run_cycle();
    run_cycle();
    n_chk++;
    if (seq.size() < 2 || seq[0] !== 2'd1 || seq[1] !== 2'd3)
      $display("FAIL release_order: got %0d,%0d want 1,3",
               (seq.size() > 0) ? seq[0] : 2'd0, (seq.size() > 1) ? seq[1] : 2'd0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    in_valid = 4'hF;
    run_cycle();
    run_cycle();
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || out_chan !== 2'd0)
      $display("FAIL mid_reset_out: got v%b d%h c%0d want v0 d0 c0", out_valid, out_data, out_chan);
    else n_pass++;
    @(negedge clk);
    #1;
    n_chk++;
    if (in_ready !== 4'b0) $display("FAIL mid_reset_ready: got %b want 0000", in_ready);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0; m_last = 3;
    sb.delete();
    seq.delete();
    run_cycle();
    run_cycle();
    n_chk++;
    if (seq.size() < 1 || seq[0] !== 2'd0)
      $display("FAIL post_reset_grant: got %0d want 0", (seq.size() > 0) ? seq[0] : 2'd3);
    else n_pass++;
  endtask

  task automatic test_ch3_sel_range();
    in_valid = 4'h0;
    out_ready = 1'b1;
    mode3 = 1'b1; in_valid3 = 3'b010; out_ready3 = 1'b1;
    #1;
    n_chk++;
    if (in_ready3 !== 3'b010) $display("FAIL c3_rr_first: got %b want 010", in_ready3);
    else n_pass++;
    @(negedge clk);
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
    #1;
    n_chk++;
    if (in_ready3 !== 3'b000) $display("FAIL c3_sel_oob_ready: got %b want 000", in_ready3);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_chk++;
    if (out_valid3 !== 1'b0 || in_ready3 !== 3'b000)
      $display("FAIL c3_sel_oob_idle: got v%b rdy %b want v0 rdy 000", out_valid3, in_ready3);
    else n_pass++;
    mode3 = 1'b1;
    #1;
    n_chk++;
    if (in_ready3 !== 3'b100) $display("FAIL c3_rr_resume: got %b want 100", in_ready3);
    else n_pass++;
    @(negedge clk);
    #1;
    n_chk++;
    if (out_valid3 !== 1'b1 || out_chan3 !== 2'd2 || out_data3 !== 4'hC)
      $display("FAIL c3_word: got v%b c%0d d%h want v1 c2 dc", out_valid3, out_chan3, out_data3);
    else n_pass++;
    n_chk++;
    if (in_ready3 !== 3'b001) $display("FAIL c3_wrap: got %b want 001", in_ready3);
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_sel();
    test_sel_invalid();
    test_back_to_back();
    test_rr_sparse_backpressure();
    test_reset_mid();
    test_ch3_sel_range();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
